// File: rtl/proc_dispatcher_pkg.sv
// Shared types for the processor-array dispatcher: instruction opcodes,
// the per-command dispatch sequence states and the instruction beat layout.
package proc_dispatcher_pkg;

    typedef enum logic [1:0] {
        INSTR_NOP   = 2'b00,
        INSTR_LD    = 2'b01,
        INSTR_INFO  = 2'b10,
        INSTR_STORE = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LD1,
        ST_LD2,
        ST_INFO,
        ST_STORE
    } dispatch_state_t;

    localparam int INSTR_PAYLOAD_W = 16;

    typedef struct packed {
        opcode_t                      opcode;
        logic [INSTR_PAYLOAD_W-1:0]   payload;
    } instr_t;

    function automatic instr_t make_instr(opcode_t opcode,
                                          logic [INSTR_PAYLOAD_W-1:0] payload);
        instr_t beat;
        beat.opcode  = opcode;
        beat.payload = payload;
        return beat;
    endfunction

endpackage

// File: rtl/proc_dispatcher_if.sv
// Command, processor-array and completion signals of the dispatcher.
// The dispatcher takes the slave side; issue logic / array model take master.
interface proc_dispatcher_if #(
    parameter int PROC_COUNT = 4,
    parameter int ID_W       = 8,
    parameter int ADDR_W     = 16,
    parameter int COUNT_W    = 8,
    parameter int OP_W       = 4
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_W-1:0]       cmd_id;
    logic [ADDR_W-1:0]     addr_0;
    logic [ADDR_W-1:0]     addr_1;
    logic [ADDR_W-1:0]     wr_addr;
    logic [COUNT_W-1:0]    count;
    logic [OP_W-1:0]       op;
    logic [PROC_COUNT-1:0] busy_proc;
    logic [PROC_COUNT-1:0] finish_proc;
    logic [PROC_COUNT-1:0] en_proc;
    logic [PROC_COUNT-1:0] ack_proc;
    logic [ADDR_W+1:0]     instr;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic                  done_ready;
    logic                  err_spurious;

    modport master (
        output cmd_valid, cmd_id, addr_0, addr_1, wr_addr, count, op,
               busy_proc, finish_proc, done_ready,
        input  cmd_ready, en_proc, ack_proc, instr, done_valid, done_id,
               err_spurious
    );

    modport slave (
        input  cmd_valid, cmd_id, addr_0, addr_1, wr_addr, count, op,
               busy_proc, finish_proc, done_ready,
        output cmd_ready, en_proc, ack_proc, instr, done_valid, done_id,
               err_spurious
    );

endinterface

// File: rtl/proc_dispatcher_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted
// index; the pointer moves only when the owner consumes the grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;

    // N is a power of two, so the candidate index wraps for free
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = last + IW'(i);
            if (!any && req[cand]) begin
                any         = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(N - 1);
        end else if (advance && any) begin
            last <= index;
        end
    end

endmodule

// File: rtl/proc_dispatcher.sv
// Dispatches one command at a time to a free SIMD processor as a four-beat
// instruction stream and returns finished command IDs upstream.
module proc_dispatcher
    import proc_dispatcher_pkg::*;
#(
    parameter int PROC_COUNT = 4,
    parameter int ID_W       = 8,
    parameter int ADDR_W     = 16,
    parameter int COUNT_W    = 8,
    parameter int OP_W       = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    proc_dispatcher_if.slave   bus
);

    localparam int IW = $clog2(PROC_COUNT);

    dispatch_state_t       state;
    logic [PROC_COUNT-1:0] running;
    logic [PROC_COUNT-1:0] pending;
    logic [PROC_COUNT-1:0] free;
    logic [PROC_COUNT-1:0] sel_grant;
    logic [PROC_COUNT-1:0] done_grant;
    logic [IW-1:0]         sel_index;
    logic [IW-1:0]         done_index;
    logic                  sel_any;
    logic                  done_any;
    logic                  accept;
    logic                  done_slot_open;
    logic                  load;

    logic [ID_W-1:0]       id_table [PROC_COUNT];
    logic [PROC_COUNT-1:0] sel_q;
    logic [ADDR_W-1:0]     addr0_q;
    logic [ADDR_W-1:0]     addr1_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [COUNT_W-1:0]    count_q;
    logic [OP_W-1:0]       op_q;

    assign free           = ~bus.busy_proc & ~running;
    assign bus.cmd_ready  = !i_rst && (state == ST_IDLE) && sel_any;
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign done_slot_open = !bus.done_valid || bus.done_ready;
    assign load           = done_slot_open && done_any;

    rr_arbiter #(.N(PROC_COUNT)) u_sel_arb (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (free),
        .advance (accept),
        .grant   (sel_grant),
        .index   (sel_index),
        .any     (sel_any)
    );

    rr_arbiter #(.N(PROC_COUNT)) u_done_arb (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (pending),
        .advance (load),
        .grant   (done_grant),
        .index   (done_index),
        .any     (done_any)
    );

    // Command fields and the owning ID are plain data captured at accept
    always_ff @(posedge i_clk) begin
        if (accept) begin
            id_table[sel_index] <= bus.cmd_id;
            sel_q               <= sel_grant;
            addr0_q             <= bus.addr_0;
            addr1_q             <= bus.addr_1;
            wr_addr_q           <= bus.wr_addr;
            count_q             <= bus.count;
            op_q                <= bus.op;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            bus.en_proc  <= '0;
            bus.ack_proc <= '0;
            bus.instr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_SELECT;
                        bus.en_proc <= sel_grant;
                    end
                end
                ST_SELECT: begin
                    state        <= ST_LD1;
                    bus.en_proc  <= '0;
                    bus.ack_proc <= sel_q;
                    bus.instr    <= {INSTR_LD, addr0_q};
                end
                ST_LD1: begin
                    state     <= ST_LD2;
                    bus.instr <= {INSTR_LD, addr1_q};
                end
                ST_LD2: begin
                    state     <= ST_INFO;
                    bus.instr <= {INSTR_INFO, ADDR_W'({count_q, op_q})};
                end
                ST_INFO: begin
                    state     <= ST_STORE;
                    bus.instr <= {INSTR_STORE, wr_addr_q};
                end
                ST_STORE: begin
                    state        <= ST_IDLE;
                    bus.ack_proc <= '0;
                    bus.instr    <= '0;
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.en_proc  <= '0;
                    bus.ack_proc <= '0;
                    bus.instr    <= '0;
                end
            endcase
        end
    end

    // A processor stays running until its completion is in the done register,
    // which caps outstanding completions at one per processor.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            running          <= '0;
            pending          <= '0;
            bus.done_valid   <= 1'b0;
            bus.done_id      <= '0;
            bus.err_spurious <= 1'b0;
        end else begin
            running <= (running | (accept ? sel_grant : '0))
                       & ~(load ? done_grant : '0);
            pending <= (pending | (bus.finish_proc & running))
                       & ~(load ? done_grant : '0);
            bus.err_spurious <= bus.err_spurious | (|(bus.finish_proc & ~running));
            if (done_slot_open) begin
                bus.done_valid <= done_any;
                if (done_any) begin
                    bus.done_id <= id_table[done_index];
                end
            end
        end
    end

endmodule

// File: tb/tb_proc_dispatcher.sv
// Scoreboard bench for proc_dispatcher: stimulus queues expected beats and
// done IDs, a negedge monitor pops and compares whenever the DUT presents them.
module tb_proc_dispatcher;
    import proc_dispatcher_pkg::*;

    localparam int PC      = 4;
    localparam int ID_W    = 8;
    localparam int ADDR_W  = 16;
    localparam int COUNT_W = 8;
    localparam int OP_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_dispatcher_if #(.PROC_COUNT(PC), .ID_W(ID_W), .ADDR_W(ADDR_W),
                         .COUNT_W(COUNT_W), .OP_W(OP_W)) bus ();

    proc_dispatcher #(.PROC_COUNT(PC), .ID_W(ID_W), .ADDR_W(ADDR_W),
                      .COUNT_W(COUNT_W), .OP_W(OP_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [PC-1:0]     en;
        logic [PC-1:0]     ack;
        logic [ADDR_W+1:0] instr;
        bit                last;
    } beat_t;

    beat_t           exp_beats[$];
    logic [ID_W-1:0] exp_done[$];
    int              checks  = 0;
    int              errors  = 0;
    bit              started = 1'b0;
    bit              want_next = 1'b0;
    beat_t           mb;
    logic [ID_W-1:0] md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input int p, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] wa, input logic [7:0] cnt,
                            input logic [3:0] op, input int n);
        beat_t s[5];
        logic [PC-1:0] oh;
        oh   = PC'(1 << p);
        s[0] = '{en: oh, ack: '0, instr: '0, last: 1'b0};
        s[1] = '{en: '0, ack: oh, instr: make_instr(INSTR_LD, a0), last: 1'b0};
        s[2] = '{en: '0, ack: oh, instr: make_instr(INSTR_LD, a1), last: 1'b0};
        s[3] = '{en: '0, ack: oh, instr: make_instr(INSTR_INFO, 16'({cnt, op})), last: 1'b0};
        s[4] = '{en: '0, ack: oh, instr: make_instr(INSTR_STORE, wa), last: 1'b0};
        for (int i = 0; i < n; i++) begin
            s[i].last = (i == n - 1);
            exp_beats.push_back(s[i]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [PC-1:0] m);
        bus.finish_proc = m;
        @(posedge clk);
        #1;
        bus.finish_proc = '0;
    endtask

    task automatic send(input logic [7:0] id, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] wa, input logic [7:0] cnt, input logic [3:0] op);
        int n;
        bus.cmd_id    = id;
        bus.addr_0    = a0;
        bus.addr_1    = a1;
        bus.wr_addr   = wa;
        bus.count     = cnt;
        bus.op        = op;
        bus.cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (bus.en_proc != '0 || bus.ack_proc != '0) begin
                if (exp_beats.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: en %0h ack %0h instr %0h at %0t",
                             bus.en_proc, bus.ack_proc, bus.instr, $time);
                end else begin
                    mb = exp_beats.pop_front();
                    chk("beat_en", 32'(bus.en_proc), 32'(mb.en));
                    chk("beat_ack", 32'(bus.ack_proc), 32'(mb.ack));
                    chk("beat_instr", 32'(bus.instr), 32'(mb.instr));
                    want_next = !mb.last;
                end
            end else begin
                if (want_next) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_gap: actual no beat, expected a beat at %0t", $time);
                end
                want_next = 1'b0;
                chk("idle_instr", 32'(bus.instr), 32'd0);
            end
            if (bus.done_valid && bus.done_ready) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual id %0h, expected none at %0t",
                             bus.done_id, $time);
                end else begin
                    md = exp_done.pop_front();
                    chk("done_id", 32'(bus.done_id), 32'(md));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_id      = '0;
        bus.addr_0      = '0;
        bus.addr_1      = '0;
        bus.wr_addr     = '0;
        bus.count       = '0;
        bus.op          = '0;
        bus.busy_proc   = '0;
        bus.finish_proc = '0;
        bus.done_ready  = 1'b1;

        // Reset values
        cyc(2);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_en", 32'(bus.en_proc), 32'd0);
        chk("rst_ack", 32'(bus.ack_proc), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_done_id", 32'(bus.done_id), 32'd0);
        chk("rst_err", 32'(bus.err_spurious), 32'd0);
        started = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic dispatch and ready latency
        push_seq(0, 16'h0100, 16'h0200, 16'h0300, 8'd8, 4'd3, 5);
        send(8'd5, 16'h0100, 16'h0200, 16'h0300, 8'd8, 4'd3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("ready_latency", 32'(bus.cmd_ready), (k == 6) ? 32'd1 : 32'd0);
        end
        cyc(1);

        // Round-robin
        do_reset();
        push_seq(0, 16'h1000, 16'h1001, 16'h1002, 8'd1, 4'd1, 5);
        send(8'd1, 16'h1000, 16'h1001, 16'h1002, 8'd1, 4'd1);
        push_seq(1, 16'h2000, 16'h2001, 16'h2002, 8'd2, 4'd2, 5);
        send(8'd2, 16'h2000, 16'h2001, 16'h2002, 8'd2, 4'd2);
        push_seq(2, 16'h3000, 16'h3001, 16'h3002, 8'd3, 4'd3, 5);
        send(8'd3, 16'h3000, 16'h3001, 16'h3002, 8'd3, 4'd3);
        exp_done.push_back(8'd2);
        pulse(4'b0010);
        cyc(3);
        bus.busy_proc = 4'b0010;
        push_seq(3, 16'h4000, 16'h4001, 16'h4002, 8'd4, 4'd4, 5);
        send(8'd4, 16'h4000, 16'h4001, 16'h4002, 8'd4, 4'd4);
        cyc(6);

        // All running, then one processor freed
        bus.busy_proc = '0;
        push_seq(1, 16'h6000, 16'h6001, 16'h6002, 8'd6, 4'd6, 5);
        send(8'd6, 16'h6000, 16'h6001, 16'h6002, 8'd6, 4'd6);
        cyc(6);
        @(negedge clk);
        chk("all_running_ready", 32'(bus.cmd_ready), 32'd0);
        cyc(1);
        exp_done.push_back(8'd3);
        pulse(4'b0100);
        @(negedge clk);
        chk("freed_ready_early", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        chk("freed_ready", 32'(bus.cmd_ready), 32'd1);
        cyc(1);
        push_seq(2, 16'h7000, 16'h7001, 16'h7002, 8'd7, 4'd7, 5);
        send(8'd7, 16'h7000, 16'h7001, 16'h7002, 8'd7, 4'd7);
        cyc(6);

        // Simultaneous finishes with back-pressure
        bus.done_ready = 1'b0;
        exp_done.push_back(8'd4);
        exp_done.push_back(8'd6);
        pulse(4'b1010);
        @(negedge clk);
        chk("simul_valid_early", 32'(bus.done_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("simul_hold_valid", 32'(bus.done_valid), 32'd1);
            chk("simul_hold_id", 32'(bus.done_id), 32'd4);
        end
        cyc(1);
        bus.done_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        @(negedge clk);
        chk("simul_drained", 32'(bus.done_valid), 32'd0);
        cyc(1);
        bus.done_ready = 1'b1;

        // Spurious finish
        chk("spur_err_before", 32'(bus.err_spurious), 32'd0);
        pulse(4'b1000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("spur_err", 32'(bus.err_spurious), 32'd1);
            chk("spur_no_done", 32'(bus.done_valid), 32'd0);
        end
        cyc(1);

        // Reset during LD2
        push_seq(3, 16'h9000, 16'h9001, 16'h9002, 8'd9, 4'd9, 3);
        send(8'd9, 16'h9000, 16'h9001, 16'h9002, 8'd9, 4'd9);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        chk("midrst_en", 32'(bus.en_proc), 32'd0);
        chk("midrst_ack", 32'(bus.ack_proc), 32'd0);
        chk("midrst_instr", 32'(bus.instr), 32'd0);
        chk("midrst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("midrst_done_id", 32'(bus.done_id), 32'd0);
        chk("midrst_err", 32'(bus.err_spurious), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_seq(0, 16'hA000, 16'hA001, 16'hA002, 8'd10, 4'd10, 5);
        send(8'd10, 16'hA000, 16'hA001, 16'hA002, 8'd10, 4'd10);
        cyc(6);
        exp_done.push_back(8'd10);
        pulse(4'b0001);
        cyc(4);

        chk("beats_left", 32'(exp_beats.size()), 32'd0);
        chk("done_left", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
